// File: rtl/div_iter_if.sv
// Launch/result bundle between the Execute stage and the iterative divider.
interface div_iter_if #(parameter int unsigned XLEN = 64);
    logic            StartE;
    logic            FlushE;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic [2:0]      Funct3E;
    logic            W64E;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] ResultE;

    modport master (
        output StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E,
        input  BusyE, DoneE, ResultE
    );

    modport slave (
        input  StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E,
        output BusyE, DoneE, ResultE
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Define DIV_WORD_OPS_EN (XLEN=64 only) to enable the DIVW/DIVUW/REMW/REMUW forms via W64E.
module div_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    div_iter_if.slave  bus
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic            busy_d, done_d, launch, load_res;

    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q, div_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q_q, neg_r_q, is_rem_q;

    logic            is_signed, word, neg_a, neg_b, div0, ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, q_init, min_neg, spec_raw, spec_res;

    logic [2*XLEN:0] shifted;
    logic [XLEN:0]   r_sh, t, r_new;
    logic [XLEN-1:0] q_new, q_fin, r_fin, fin_raw, fin_res;

`ifdef DIV_WORD_OPS_EN
    logic            word_q;
    logic            unused_f3;
    assign unused_f3 = bus.Funct3E[2];
`else
    logic            unused_ins;
    assign unused_ins = ^{bus.Funct3E[2], bus.W64E};
`endif

    // Operand conditioning and special-case detection at launch
    always_comb begin
        is_signed = ~bus.Funct3E[0];
        a_ext     = bus.ForwardedSrcAE;
        b_ext     = bus.ForwardedSrcBE;
        min_neg   = {1'b1, {(XLEN-1){1'b0}}};
`ifdef DIV_WORD_OPS_EN
        word = bus.W64E;
        if (word) begin
            a_ext   = is_signed ? XLEN'($signed(bus.ForwardedSrcAE[31:0])) : XLEN'(bus.ForwardedSrcAE[31:0]);
            b_ext   = is_signed ? XLEN'($signed(bus.ForwardedSrcBE[31:0])) : XLEN'(bus.ForwardedSrcBE[31:0]);
            min_neg = XLEN'($signed(32'h8000_0000));
        end
`else
        word = 1'b0;
`endif
        neg_a   = is_signed & a_ext[XLEN-1];
        neg_b   = is_signed & b_ext[XLEN-1];
        abs_a   = neg_a ? -a_ext : a_ext;
        abs_b   = neg_b ? -b_ext : b_ext;
        // Word ops start with |A| in the upper half so 32 shifts drain it into R
        q_init  = word ? (abs_a << 32) : abs_a;
        div0    = (b_ext == '0);
        ovf     = is_signed && (a_ext == min_neg) && (b_ext == '1);
        special = div0 | ovf;
        if (bus.Funct3E[1])
            spec_raw = div0 ? a_ext : '0;
        else
            spec_raw = div0 ? '1 : a_ext;
        spec_res = spec_raw;
`ifdef DIV_WORD_OPS_EN
        if (word) spec_res = XLEN'($signed(spec_raw[31:0]));
`endif
    end

    // One restoring step plus sign fix-up of the would-be final result
    always_comb begin
        shifted = {rem_q, quo_q} << 1;
        r_sh    = shifted[2*XLEN:XLEN];
        t       = r_sh - {1'b0, div_q};
        r_new   = r_sh;
        q_new   = shifted[XLEN-1:0];
        if (!t[XLEN]) begin
            r_new = t;
            q_new = shifted[XLEN-1:0] | XLEN'(1);
        end
        q_fin   = neg_q_q ? -q_new : q_new;
        r_fin   = neg_r_q ? -r_new[XLEN-1:0] : r_new[XLEN-1:0];
        fin_raw = is_rem_q ? r_fin : q_fin;
        fin_res = fin_raw;
`ifdef DIV_WORD_OPS_EN
        if (word_q) fin_res = XLEN'($signed(fin_raw[31:0]));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        load_res = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.StartE && !bus.FlushE) begin
                    launch = 1'b1;
                    if (special) begin
                        state_d  = DONE;
                        load_res = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.FlushE) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            is_rem_q    <= 1'b0;
            bus.BusyE   <= 1'b0;
            bus.DoneE   <= 1'b0;
            bus.ResultE <= '0;
`ifdef DIV_WORD_OPS_EN
            word_q      <= 1'b0;
`endif
        end else begin
            bus.BusyE <= busy_d;
            bus.DoneE <= done_d;
            if (load_res)
                bus.ResultE <= (state_q == IDLE) ? spec_res : fin_res;
            if (launch) begin
                rem_q    <= '0;
                quo_q    <= q_init;
                div_q    <= abs_b;
                cnt_q    <= word ? CW'(31) : CW'(XLEN-1);
                neg_q_q  <= neg_a ^ neg_b;
                neg_r_q  <= neg_a;
                is_rem_q <= bus.Funct3E[1];
`ifdef DIV_WORD_OPS_EN
                word_q   <= word;
`endif
            end else if (state_q == BUSY) begin
                rem_q <= r_new;
                quo_q <= q_new;
                if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule
